// File: rtl/clk_div_ctrl_pkg.sv
// Shared types, reset defaults and configuration validity check for clk_div_ctrl.
package clk_div_ctrl_pkg;

  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_PERIOD_VAL = 2;
  localparam int unsigned DEF_HIGH_VAL   = 1;
  // Struct fields are sized for the widest supported CNT_W; narrower fields are zero-extended.
  localparam int unsigned CFG_MAX_W      = 32;

  typedef enum logic [1:0] {
    StIdle,
    StPhaseDly,
    StRun,
    StDrain
  } state_e;

  typedef struct packed {
    logic [CFG_MAX_W-1:0] period;
    logic [CFG_MAX_W-1:0] high;
    logic [CFG_MAX_W-1:0] phase;
  } cfg_t;

  function automatic logic cfg_is_valid(input cfg_t c);
    return (c.period >= CFG_MAX_W'(2)) &&
           (c.high >= CFG_MAX_W'(1)) &&
           (c.high <= c.period - CFG_MAX_W'(1)) &&
           (c.phase <= c.period - CFG_MAX_W'(1));
  endfunction

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// Configuration handshake, validation, error pulse and shadow/active registers.
// The shadow is copied to the active set on a period boundary, or at once when idle.
module clk_div_cfg_shadow
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_VAL,
  parameter int unsigned DEF_HIGH   = DEF_HIGH_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idle,
  input  logic             boundary,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] act_high,
  output logic [CNT_W-1:0] act_phase
);

  cfg_t             cand;
  logic             cand_ok;
  logic             xfer;
  logic             apply;
  logic             shadow_full_q;
  logic             cfg_err_q;
  logic [CNT_W-1:0] sh_period_q, sh_high_q, sh_phase_q;
  logic [CNT_W-1:0] act_period_q, act_high_q, act_phase_q;

  always_comb begin
    cand        = '0;
    cand.period = CFG_MAX_W'(cfg_period);
    cand.high   = CFG_MAX_W'(cfg_high);
    cand.phase  = CFG_MAX_W'(cfg_phase);
  end

  assign cand_ok   = cfg_is_valid(cand);
  assign cfg_ready = !shadow_full_q;
  assign xfer      = cfg_valid && cfg_ready;
  // Idle case covers a shadow left behind by an abort from the phase delay.
  assign apply     = shadow_full_q && (boundary || idle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_full_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      sh_period_q   <= '0;
      sh_high_q     <= '0;
      sh_phase_q    <= '0;
      act_period_q  <= CNT_W'(DEF_PERIOD);
      act_high_q    <= CNT_W'(DEF_HIGH);
      act_phase_q   <= '0;
    end else begin
      cfg_err_q <= xfer && !cand_ok;
      if (apply) begin
        act_period_q  <= sh_period_q;
        act_high_q    <= sh_high_q;
        act_phase_q   <= sh_phase_q;
        shadow_full_q <= 1'b0;
      end
      // xfer implies an empty shadow, so this never collides with apply.
      if (xfer && cand_ok) begin
        if (idle) begin
          act_period_q <= cfg_period;
          act_high_q   <= cfg_high;
          act_phase_q  <= cfg_phase;
        end else begin
          sh_period_q   <= cfg_period;
          sh_high_q     <= cfg_high;
          sh_phase_q    <= cfg_phase;
          shadow_full_q <= 1'b1;
        end
      end
    end
  end

  assign cfg_err    = cfg_err_q;
  assign act_period = act_period_q;
  assign act_high   = act_high_q;
  assign act_phase  = act_phase_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable, glitch-free clock waveform generator with boundary-aligned reconfiguration.
// Define CLK_DIV_CTRL_CNT_EN to add the 32-bit completed-period counter output period_cnt.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_VAL,
  parameter int unsigned DEF_HIGH   = DEF_HIGH_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             clk_out,
  output logic             running,
  output logic             cfg_err
`ifdef CLK_DIV_CTRL_CNT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clk_out_q;
  logic             running_q;
  logic [CNT_W-1:0] act_period, act_high, act_phase;
  logic             in_period;
  logic             boundary;
  logic             phase_done;

  assign in_period  = (state_q == StRun) || (state_q == StDrain);
  assign boundary   = in_period && (cnt_q == act_period - CNT_W'(1));
  assign phase_done = (cnt_q == act_phase - CNT_W'(1));

  clk_div_cfg_shadow #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH)
  ) u_cfg (
    .clk        (clk),
    .rst_n      (rst_n),
    .idle       (state_q == StIdle),
    .boundary   (boundary),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .cfg_err    (cfg_err),
    .act_period (act_period),
    .act_high   (act_high),
    .act_phase  (act_phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      running_q <= (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          clk_out_q <= 1'b0;
          cnt_q     <= '0;
          if (enable) state_q <= (act_phase != '0) ? StPhaseDly : StRun;
        end
        StPhaseDly: begin
          clk_out_q <= 1'b0;
          if (!enable) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (phase_done) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StRun, StDrain: begin
          // Output lags cnt by one edge so each period is exactly high/low cycles long.
          clk_out_q <= (cnt_q < act_high);
          if (boundary) begin
            cnt_q   <= '0;
            state_q <= enable ? StRun : StIdle;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!enable) state_q <= StDrain;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [31:0] period_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q <= '0;
    end else if (boundary) begin
      period_cnt_q <= period_cnt_q + 32'd1;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

  assign clk_out = clk_out_q;
  assign running = running_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random traffic against a
// period-level behavioural model.
module tb_clk_div_ctrl;

  localparam int unsigned W = 16;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_CLOCK = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_high;
  logic [W-1:0] cfg_phase;
  logic         clk_out;
  logic         running;
  logic         cfg_err;
`ifdef CLK_DIV_CTRL_CNT_EN
  logic [31:0]  period_cnt;
`endif

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W      (W),
    .DEF_PERIOD (2),
    .DEF_HIGH   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .clk_out    (clk_out),
    .running    (running),
    .cfg_err    (cfg_err)
`ifdef CLK_DIV_CTRL_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  // Model: the active waveform config, an optional pending config, and where we are
  // in the phase delay or the current period.
  int unsigned a_p, a_h, a_ph;
  int unsigned s_p, s_h, s_ph;
  bit          s_full;
  int          mode;
  int unsigned pos;
  bit          e_clk, e_run, e_err;
  int unsigned e_pcnt;

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    a_p = 2; a_h = 1; a_ph = 0;
    s_p = 0; s_h = 0; s_ph = 0;
    s_full = 1'b0;
    mode = M_IDLE;
    pos = 0;
    e_clk = 1'b0; e_run = 1'b0; e_err = 1'b0;
    e_pcnt = 0;
  endtask

  task automatic check1(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %b expected %b at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs();
    check1("clk_out", clk_out, e_clk);
    check1("running", running, e_run);
    check1("cfg_ready", cfg_ready, !s_full);
    check1("cfg_err", cfg_err, e_err);
`ifdef CLK_DIV_CTRL_CNT_EN
    check32("period_cnt", period_cnt, e_pcnt);
`endif
  endtask

  // One clock edge: advance the model from the inputs seen at the edge, then compare.
  task automatic step();
    bit          en, v, ok, xfer, bnd, was_idle;
    int unsigned p, h, ph;
    @(posedge clk);
    en = enable; v = cfg_valid;
    p = cfg_period; h = cfg_high; ph = cfg_phase;
    ok = (p >= 2) && (h >= 1) && (h <= p - 1) && (ph <= p - 1);
    xfer = v && !s_full;
    bnd = (mode == M_CLOCK) && (pos == a_p - 1);
    was_idle = (mode == M_IDLE);
    e_clk = (mode == M_CLOCK) && (pos < a_h);
    e_run = !was_idle;
    e_err = xfer && !ok;
    if (bnd) e_pcnt++;
    case (mode)
      M_IDLE: if (en) begin
        pos = 0;
        mode = (a_ph > 0) ? M_WAIT : M_CLOCK;
      end
      M_WAIT: begin
        if (!en) begin
          mode = M_IDLE; pos = 0;
        end else if (pos == a_ph - 1) begin
          mode = M_CLOCK; pos = 0;
        end else begin
          pos++;
        end
      end
      default: begin
        if (bnd) begin
          pos = 0;
          if (!en) mode = M_IDLE;
        end else begin
          pos++;
        end
      end
    endcase
    if (s_full && (bnd || was_idle)) begin
      a_p = s_p; a_h = s_h; a_ph = s_ph; s_full = 1'b0;
    end
    if (xfer && ok) begin
      if (was_idle) begin
        a_p = p; a_h = h; a_ph = ph;
      end else begin
        s_p = p; s_h = h; s_ph = ph; s_full = 1'b1;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_cfg(input int unsigned p, input int unsigned h, input int unsigned ph);
    cfg_valid = 1'b1;
    cfg_period = W'(p); cfg_high = W'(h); cfg_phase = W'(ph);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Default {2,1,0} after reset.
    run(4);
    enable = 1'b1; run(8);
    enable = 1'b0; run(4);

    // {5,2,0}: high two edges after enable, low three.
    send_cfg(5, 2, 0);
    enable = 1'b1; run(16);
    enable = 1'b0; run(8);

    // {4,1,3}: three-cycle start delay.
    send_cfg(4, 1, 3);
    enable = 1'b1; run(14);
    enable = 1'b0; run(6);

    // Mid-period reconfiguration {6,3,0} -> {4,2,0} through the shadow.
    send_cfg(6, 3, 0);
    enable = 1'b1; run(2);
    send_cfg(4, 2, 0);
    run(14);

    // Invalid configs while running.
    send_cfg(4, 4, 0); run(2);
    send_cfg(1, 0, 0); run(6);
    enable = 1'b0; run(8);
    send_cfg(3, 0, 0); run(2);

    // Drain at cnt=1 of {8,4,0}, then re-enable late in a draining period.
    send_cfg(8, 4, 0);
    enable = 1'b1; run(2);
    enable = 1'b0; run(10);
    enable = 1'b1; run(9);
    enable = 1'b0; run(5);
    enable = 1'b1; run(12);
    enable = 1'b0; run(10);

    // Random traffic, including invalid and dropped offers.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) enable = ~enable;
      cfg_valid  = ($urandom_range(3) == 0);
      cfg_period = W'($urandom_range(9));
      cfg_high   = W'($urandom_range(9));
      cfg_phase  = W'($urandom_range(9));
      step();
    end
    cfg_valid = 1'b0; enable = 1'b0;
    run(24);

    // Async reset while clk_out is high and a shadow config is pending.
    send_cfg(6, 3, 0);
    enable = 1'b1; run(2);
    send_cfg(4, 2, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(3);
    enable = 1'b1; run(10);
    enable = 1'b0; run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
